// File: rtl/pac_pkg.sv
// -----------------------------------------------------------------------------
// pac_pkg
// Shared definitions for the serial adder checker: FSM state encoding and the
// default word / counter widths used by parity_add_checker.
// Optional build macro honoured by the design: PAC_PARITY_CHECK_EN (see
// pac_bit_ref for its effect).
// -----------------------------------------------------------------------------
package pac_pkg;

    // Default bits per serial word and width of the count/position fields.
    localparam int PAC_WIDTH_DEF = 8;
    localparam int PAC_CNT_W_DEF = 6;

    // FSM state encoding.
    typedef logic [1:0] pac_state_t;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

endpackage

// File: rtl/pac_bit_ref.sv
// -----------------------------------------------------------------------------
// pac_bit_ref
// Combinational reference for one bit slice of a ripple adder. Computes the
// expected sum and carry from the operand bits and the carry-in, and flags a
// mismatch against the values returned by the adder under test.
//
// Build macro: PAC_PARITY_CHECK_EN
//   defined   -> the parity prediction (ai^bi^cin^fi) must equal (si^ci^fi1)
//   undefined -> fi and fi1 are ignored; only sum and carry are compared
//
// Ports
//   ai, bi   in   operand bits of this slice
//   fi       in   input parity bit of this slice
//   cin      in   carry into this slice
//   si, ci   in   sum and carry-out returned by the adder under test
//   fi1      in   output parity returned by the adder under test
//   exp_c    out  expected carry-out (feeds the next slice's carry-in)
//   mismatch out  returned values disagree with the reference
// -----------------------------------------------------------------------------
module pac_bit_ref (
    input  logic ai,
    input  logic bi,
    input  logic fi,
    input  logic cin,
    input  logic si,
    input  logic ci,
    input  logic fi1,
    output logic exp_c,
    output logic mismatch
);

    logic w_exp_s;
    logic w_parity_fail;

    assign w_exp_s = ai ^ bi ^ cin;
    assign exp_c   = (ai & bi) | (ai & cin) | (bi & cin);

`ifdef PAC_PARITY_CHECK_EN
    // Parity is predicted from the inputs and compared with the parity
    // reconstructed from the returned sum, carry and output parity bit.
    assign w_parity_fail = (ai ^ bi ^ cin ^ fi) != (si ^ ci ^ fi1);
`else
    logic w_unused_par;
    assign w_unused_par  = fi ^ fi1;
    assign w_parity_fail = 1'b0;
`endif

    assign mismatch = (si != w_exp_s) | (ci != exp_c) | w_parity_fail;

endmodule

// File: rtl/parity_add_checker.sv
// -----------------------------------------------------------------------------
// parity_add_checker
// Checks a bit-serial (LSB first) ripple addition one slice per accepted beat.
// After WIDTH beats it presents a word report: whether any beat mismatched,
// how many beats mismatched (saturating) and the index of the first one.
//
// Build macro: PAC_PARITY_CHECK_EN (enables the per-beat parity comparison).
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   beat offered
//   in_ready   out  checker can accept a beat (low only while reporting)
//   ai,bi,fi,ci1 in operand bits, input parity and carry-in of the slice
//   si,ci,fi1  in   sum, carry-out and output parity from the adder under test
//   out_valid  out  word report available
//   out_ready  in   report consumed when out_valid is also high
//   err        out  word had at least one mismatching beat
//   err_cnt    out  number of mismatching beats, saturating
//   err_pos    out  index of the first mismatching beat (0 when err=0)
// -----------------------------------------------------------------------------
module parity_add_checker
    import pac_pkg::*;
#(
    parameter int WIDTH = PAC_WIDTH_DEF,
    parameter int CNT_W = PAC_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ai,
    input  logic             bi,
    input  logic             fi,
    input  logic             ci1,
    input  logic             si,
    input  logic             ci,
    input  logic             fi1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] err_pos
);

    pac_state_t       r_state;
    logic [CNT_W-1:0] r_idx;
    logic             r_carry;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pos;

    logic w_first;
    logic w_last;
    logic w_cin;
    logic w_exp_c;
    logic w_bit_mis;
    logic w_chain_brk;
    logic w_bad;
    logic w_accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_first = (r_idx == '0);
    assign w_last  = (r_idx == CNT_W'(WIDTH - 1));

    // Beat 0 takes the carry from the bus; later beats chain the reference
    // carry so a wrong ci from the adder does not poison the next prediction.
    assign w_cin = w_first ? ci1 : r_carry;

    pac_bit_ref u_bit_ref (
        .ai       (ai),
        .bi       (bi),
        .fi       (fi),
        .cin      (w_cin),
        .si       (si),
        .ci       (ci),
        .fi1      (fi1),
        .exp_c    (w_exp_c),
        .mismatch (w_bit_mis)
    );

    // The carry the adder feeds back on ci1 must match the chained carry.
    assign w_chain_brk = !w_first && (ci1 != r_carry);
    assign w_bad       = w_bit_mis | w_chain_brk;

    assign in_ready  = (r_state != ST_REPORT);
    assign out_valid = (r_state == ST_REPORT);
    assign w_accept  = in_valid && in_ready;

    assign err     = r_err;
    assign err_cnt = r_cnt;
    assign err_pos = r_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_pos   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_accept) begin
                        r_carry <= w_exp_c;
                        if (w_bad) begin
                            r_cnt <= sat_inc(r_cnt);
                            if (!r_err) begin
                                r_err <= 1'b1;
                                r_pos <= r_idx;
                            end
                        end
                        if (w_last) begin
                            r_state <= ST_REPORT;
                        end else begin
                            r_idx   <= r_idx + CNT_W'(1);
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_REPORT: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        r_pos   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_add_checker.sv
// -----------------------------------------------------------------------------
// tb_parity_add_checker
// Self-checking bench for parity_add_checker (WIDTH=8, CNT_W=6). Word reports
// are predicted from plain integer addition of the operands and compared with
// the DUT whenever a report is consumed; directed words pin known results.
// -----------------------------------------------------------------------------
module tb_parity_add_checker;

    localparam int WIDTH = 8;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             ai, bi, fi, ci1, si, ci, fi1;
    logic             out_valid;
    logic             out_ready;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] err_pos;

    parity_add_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ai        (ai),
        .bi        (bi),
        .fi        (fi),
        .ci1       (ci1),
        .si        (si),
        .ci        (ci),
        .fi1       (fi1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_cnt   (err_cnt),
        .err_pos   (err_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e;
        int c;
        int p;
    } rep_t;

    rep_t       exq[$];
    logic [6:0] word_beats[WIDTH];   // {ai,bi,fi,ci1,si,ci,fi1}
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the correct slice values come from integer addition a+b+c0.
    // Faults are injected by XOR masks; the report follows from the rules.
    task automatic build_word(input int a, input int b, input int c0,
                              input int fs, input int fc, input int ff1, input int fci1,
                              output int e_err, output int e_cnt, output int e_pos);
        int total;
        int nbad;
        int first;
        total = a + b + c0;
        nbad  = 0;
        first = -1;
        for (int k = 0; k < WIDTH; k++) begin
            int   m0, m1;
            logic a_k, b_k, f_k, cin_t, co_t, s_t, s_d, c_d, f1_d, ci1_d, bad;
            m0    = (1 << k) - 1;
            m1    = (1 << (k + 1)) - 1;
            a_k   = a[k];
            b_k   = b[k];
            f_k   = 1'($urandom_range(0, 1));
            cin_t = (k == 0) ? 1'(c0) : 1'((((a & m0) + (b & m0) + c0) >> k) & 1);
            co_t  = 1'((((a & m1) + (b & m1) + c0) >> (k + 1)) & 1);
            s_t   = 1'((total >> k) & 1);
            s_d   = s_t ^ fs[k];
            c_d   = co_t ^ fc[k];
            f1_d  = (a_k ^ b_k ^ cin_t ^ f_k ^ s_t ^ co_t) ^ ff1[k];
            ci1_d = cin_t ^ ((k == 0) ? 1'b0 : fci1[k]);
            bad   = (s_d != s_t) || (c_d != co_t) || (k > 0 && ci1_d != cin_t);
`ifdef PAC_PARITY_CHECK_EN
            bad = bad || ((a_k ^ b_k ^ cin_t ^ f_k) != (s_d ^ c_d ^ f1_d));
`endif
            if (bad) begin
                nbad++;
                if (first < 0) first = k;
            end
            word_beats[k] = {a_k, b_k, f_k, ci1_d, s_d, c_d, f1_d};
        end
        e_err = (nbad > 0) ? 1 : 0;
        e_cnt = (nbad > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : nbad;
        e_pos = (first < 0) ? 0 : first;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_beat(input int k);
        int n;
        {ai, bi, fi, ci1, si, ci, fi1} = word_beats[k];
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        if (k > 0) chk("in_ready_run", int'(in_ready), 1);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input int a, input int b, input int c0,
                             input int fs, input int fc, input int ff1, input int fci1,
                             input int gap, output rep_t r);
        int e, c, p;
        build_word(a, b, c0, fs, fc, ff1, fci1, e, c, p);
        r.e = e;
        r.c = c;
        r.p = p;
        exq.push_back(r);
        for (int k = 0; k < WIDTH; k++) begin
            drive_beat(k);
            if (k < WIDTH - 1) begin
                repeat (gap) begin
                    @(negedge clk);
                    chk("in_ready_gap", int'(in_ready), 1);
                    @(posedge clk);
                    #1;
                end
            end
        end
        chk("out_valid_latency", int'(out_valid), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) chk("report_drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_report(input string name, input int e, input int c, input int p);
        chk({name, "_err"}, int'(err), e);
        chk({name, "_cnt"}, int'(err_cnt), c);
        chk({name, "_pos"}, int'(err_pos), p);
    endtask

    // Compare process: checks each consumed report against the model queue and
    // that a stalled report holds its outputs.
    initial begin
        logic             pv, pr, pe;
        logic [CNT_W-1:0] pc, pp;
        pv = 1'b0;
        pr = 1'b0;
        pe = 1'b0;
        pc = '0;
        pp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("report_held_valid", int'(out_valid), 1);
                    chk("report_held_err", int'(err), int'(pe));
                    chk("report_held_cnt", int'(err_cnt), int'(pc));
                    chk("report_held_pos", int'(err_pos), int'(pp));
                end
                if (out_valid) chk("in_ready_in_report", int'(in_ready), 0);
                if (out_valid && out_ready) begin
                    if (exq.size() == 0) begin
                        chk("unexpected_report", 1, 0);
                    end else begin
                        rep_t r;
                        r = exq.pop_front();
                        chk("model_err", int'(err), r.e);
                        chk("model_cnt", int'(err_cnt), r.c);
                        chk("model_pos", int'(err_pos), r.p);
                    end
                end
                pv = out_valid;
                pr = out_ready;
                pe = err;
                pc = err_cnt;
                pp = err_pos;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rep_t r;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        {ai, bi, fi, ci1, si, ci, fi1} = 7'd0;
        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_cnt", int'(err_cnt), 0);
        chk("rst_pos", int'(err_pos), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Clean word 0x5A + 0x33
        send_word(32'h5A, 32'h33, 0, 0, 0, 0, 0, 0, r);
        chk("pin_clean_model", r.e * 100 + r.c * 10 + r.p, 0);
        chk_report("clean", 0, 0, 0);
        wait_idle();

        // Sum inverted on beat 3
        send_word(32'h5A, 32'h33, 0, 32'h08, 0, 0, 0, 0, r);
        chk("pin_sum3_model", r.e * 100 + r.c * 10 + r.p, 113);
        chk_report("sum3", 1, 1, 3);
        wait_idle();

        // Output parity inverted on beats 2 and 5
        send_word(32'h5A, 32'h33, 0, 0, 0, 32'h24, 0, 0, r);
`ifdef PAC_PARITY_CHECK_EN
        chk_report("par25", 1, 2, 2);
`else
        chk_report("par25", 0, 0, 0);
`endif
        wait_idle();

        // 0xFF + 0x01 with three idle cycles between beats
        send_word(32'hFF, 32'h01, 0, 0, 0, 0, 0, 3, r);
        chk_report("gap", 0, 0, 0);
        wait_idle();

        // Broken carry chain on beat 4
        send_word(32'hFF, 32'h01, 0, 0, 0, 0, 32'h10, 0, r);
        chk_report("chain4", 1, 1, 4);
        wait_idle();

        // Report stalled 5 cycles while a beat is offered
        out_ready = 1'b0;
        send_word(32'h5A, 32'h33, 0, 32'h40, 0, 0, 0, 0, r);
        {ai, bi, fi, ci1, si, ci, fi1} = 7'b1111111;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_ready", int'(in_ready), 0);
            chk_report("stall", 1, 1, 6);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release_valid", int'(out_valid), 0);
        chk("stall_release_ready", int'(in_ready), 1);

        // Reset after beat 4 of a word with an error at beat 1
        begin
            int e, c, p;
            build_word(32'h5A, 32'h33, 0, 32'h02, 0, 0, 0, e, c, p);
            for (int k = 0; k < 5; k++) drive_beat(k);
            rst_n = 1'b0;
            #2;
            chk_report("midrst", 0, 0, 0);
            chk("midrst_valid", int'(out_valid), 0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
        end
        send_word(32'h5A, 32'h33, 0, 0, 0, 0, 0, 0, r);
        chk_report("after_rst", 0, 0, 0);
        wait_idle();

        // Randomized words with sparse faults, gaps and report stalls
        for (int w = 0; w < 40; w++) begin
            int a, b, c0, fs, fc, ff1, fci1, gap;
            a    = int'($urandom_range(0, 255));
            b    = int'($urandom_range(0, 255));
            c0   = int'($urandom_range(0, 1));
            fs   = int'(($urandom & $urandom & $urandom) & 32'hFF);
            fc   = int'(($urandom & $urandom & $urandom) & 32'hFF);
            ff1  = int'(($urandom & $urandom & $urandom) & 32'hFF);
            fci1 = int'(($urandom & $urandom & $urandom) & 32'hFE);
            gap  = int'($urandom_range(0, 2));
            if (w % 5 == 0) out_ready = 1'b0;
            send_word(a, b, c0, fs, fc, ff1, fci1, gap, r);
            if (!out_ready) begin
                repeat ($urandom_range(1, 4)) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            wait_idle();
        end

        chk("queue_drained", exq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
